// File: rtl/qnn_bseg_unit.sv
// Multi-cycle execution unit for the OP_BS segment-width config and packed inner-product ops.
// Define QNN_BSEG_SIGNED_EN for signed elements in IP (W=1 elements encode +/-1).
module qnn_bseg_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            illegal_o
);
    localparam logic [2:0] F3_BS_SET = 3'd0;
    localparam logic [2:0] F3_BS_GET = 3'd1;
    localparam logic [2:0] F3_BS_IP  = 3'd2;

`ifdef QNN_BSEG_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      seg_log, op_seg;
    logic [XLEN-1:0] a_q, b_q, acc, acc_nxt, prod, imm_res;
    logic [4:0]      rd_q;
    logic [5:0]      cnt, last_idx;
    logic [3:0]      shamt;
    logic [15:0]     ea, eb, p16;
    logic            accept, last;

    assign ready_o = (state == S_IDLE) && !kill_i;
    assign valid_o = (state == S_DONE);
    assign accept  = valid_i && ready_o;
    assign shamt   = 4'd1 << op_seg;
    assign last    = (cnt == last_idx);
    assign acc_nxt = acc + prod;

    // Operands shift right by W each BUSY cycle, so the current element is always in the low bits.
    always_comb begin
        ea       = '0;
        eb       = '0;
        last_idx = 6'd63;
        unique case (op_seg)
            2'd0: begin
                ea       = {15'b0, a_q[0]};
                eb       = {15'b0, b_q[0]};
                last_idx = 6'd63;
            end
            2'd1: begin
                ea       = {{14{SIGNED_EN & a_q[1]}}, a_q[1:0]};
                eb       = {{14{SIGNED_EN & b_q[1]}}, b_q[1:0]};
                last_idx = 6'd31;
            end
            2'd2: begin
                ea       = {{12{SIGNED_EN & a_q[3]}}, a_q[3:0]};
                eb       = {{12{SIGNED_EN & b_q[3]}}, b_q[3:0]};
                last_idx = 6'd15;
            end
            2'd3: begin
                ea       = {{8{SIGNED_EN & a_q[7]}}, a_q[7:0]};
                eb       = {{8{SIGNED_EN & b_q[7]}}, b_q[7:0]};
                last_idx = 6'd7;
            end
        endcase
        // Low 16 bits of the product are the same for signed and unsigned operands.
        if (SIGNED_EN && op_seg == 2'd0)
            p16 = (a_q[0] == b_q[0]) ? 16'h0001 : 16'hFFFF;
        else
            p16 = ea * eb;
        prod = {{(XLEN-16){SIGNED_EN & p16[15]}}, p16};
    end

    always_comb begin
        imm_res = '0;
        if (funct3_i == F3_BS_SET)
            imm_res = {{(XLEN-2){1'b0}}, rs1_data_i[1:0]};
        else if (funct3_i == F3_BS_GET)
            imm_res = {{(XLEN-2){1'b0}}, seg_log};
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = (funct3_i == F3_BS_IP) ? S_BUSY : S_DONE;
            S_BUSY:  if (last) state_nxt = S_DONE;
            S_DONE:  if (ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (kill_i)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            seg_log   <= '0;
            op_seg    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            rd_q      <= '0;
            result_o  <= '0;
            rd_o      <= '0;
            illegal_o <= 1'b0;
        end else if (accept) begin
            a_q    <= rs1_data_i;
            b_q    <= rs2_data_i;
            rd_q   <= rd_i;
            op_seg <= seg_log;
            acc    <= '0;
            cnt    <= '0;
            if (funct3_i != F3_BS_IP) begin
                result_o  <= imm_res;
                rd_o      <= rd_i;
                illegal_o <= (funct3_i > F3_BS_IP);
            end
            if (funct3_i == F3_BS_SET)
                seg_log <= rs1_data_i[1:0];
        end else if (state == S_BUSY && !kill_i) begin
            acc <= acc_nxt;
            cnt <= cnt + 6'd1;
            a_q <= a_q >> shamt;
            b_q <= b_q >> shamt;
            if (last) begin
                result_o  <= acc_nxt;
                rd_o      <= rd_q;
                illegal_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_qnn_bseg_unit.sv
// Randomized bench for qnn_bseg_unit against an arithmetic model of the OP_BS ops.
module tb_qnn_bseg_unit;
    localparam logic [2:0] F3_SET = 3'd0, F3_GET = 3'd1, F3_IP = 3'd2, F3_GP2 = 3'd5;

    logic        clk = 1'b0, rstn_i = 1'b0;
    logic        valid_i = 1'b0, kill_i = 1'b0, ready_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [63:0] rs1_data_i = '0, rs2_data_i = '0;
    logic [4:0]  rd_i = '0;
    logic        ready_o, valid_o, illegal_o;
    logic [63:0] result_o;
    logic [4:0]  rd_o;

    qnn_bseg_unit #(.XLEN(64)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
        .funct3_i(funct3_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rd_i(rd_i), .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .rd_o(rd_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;

    // Outstanding instruction as predicted by the model.
    bit          pend = 0;
    int          exp_cyc = 0;
    logic [63:0] exp_res = '0;
    logic [4:0]  exp_rd = '0;
    logic        exp_ill = 1'b0;
    logic [1:0]  m_seg = 2'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_ip(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] sl);
        int w, n, ea, eb;
        longint acc;
        logic [63:0] ta, tb;
        w = 1 << sl;
        n = 64 / w;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            ta = a >> (i * w);
            tb = b >> (i * w);
            ea = int'({24'b0, ta[7:0]}) & ((1 << w) - 1);
            eb = int'({24'b0, tb[7:0]}) & ((1 << w) - 1);
`ifdef QNN_BSEG_SIGNED_EN
            if (w == 1) begin
                acc += (ea == eb) ? 1 : -1;
            end else begin
                if (ea >= (1 << (w - 1))) ea -= (1 << w);
                if (eb >= (1 << (w - 1))) eb -= (1 << w);
                acc += longint'(ea * eb);
            end
`else
            acc += longint'(ea * eb);
`endif
        end
        return acc;
    endfunction

    function automatic logic [63:0] model_res(input logic [2:0] f3, input logic [63:0] a,
                                              input logic [63:0] b, input logic [1:0] sl);
        if (f3 == F3_SET) return {62'b0, a[1:0]};
        if (f3 == F3_GET) return {62'b0, sl};
        if (f3 == F3_IP)  return model_ip(a, b, sl);
        return 64'd0;
    endfunction

    // One compare process: checks outputs every cycle once the bench is out of reset.
    always @(negedge clk) begin
        if (chk_en) begin
            if (pend && cyc >= exp_cyc) begin
                chk("valid_o", {63'b0, valid_o}, 64'd1);
                chk("result_o", result_o, exp_res);
                chk("rd_o", {59'b0, rd_o}, {59'b0, exp_rd});
                chk("illegal_o", {63'b0, illegal_o}, {63'b0, exp_ill});
                chk("ready_o_done", {63'b0, ready_o}, 64'd0);
            end else if (pend) begin
                chk("valid_o_early", {63'b0, valid_o}, 64'd0);
                chk("ready_o_busy", {63'b0, ready_o}, 64'd0);
            end else begin
                chk("valid_o_idle", {63'b0, valid_o}, 64'd0);
                chk("ready_o_idle", {63'b0, ready_o}, {63'b0, !kill_i});
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input int stall, input int kill_at,
                         input bit use_lit, input logic [63:0] lit, input int lit_lat);
        int waited, k, seen, lat;
        bit hs, kl;
        logic [63:0] res;
        res = model_res(f3, a, b, m_seg);
        lat = (f3 == F3_IP) ? (64 >> m_seg) + 1 : 1;
        if (use_lit) begin
            chk("model_pin_res", res, lit);
            res = lit;
        end
        if (lit_lat > 0) begin
            chk("model_pin_lat", 64'(lat), 64'(lit_lat));
            lat = lit_lat;
        end
        @(posedge clk); #1;
        waited = 0;
        while (!ready_o && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!ready_o) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: ready_o still 0 after %0d cycles", waited);
            return;
        end
        valid_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_i = rd;
        @(posedge clk); #1;
        valid_i = 1'b0; funct3_i = 3'($urandom); rs1_data_i = {$urandom, $urandom};
        rs2_data_i = {$urandom, $urandom}; rd_i = 5'($urandom);
        if (f3 == F3_SET) m_seg = a[1:0];
        exp_res = res; exp_rd = rd; exp_ill = (f3 > F3_IP);
        exp_cyc = cyc + lat - 1;
        pend = 1;
        k = 1; seen = 0;
        while (pend && k < lat + stall + 10) begin
            if (k == kill_at) kill_i = 1'b1;
            if (cyc >= exp_cyc) begin
                if (seen >= stall) ready_i = 1'b1;
                seen++;
            end
            hs = (cyc >= exp_cyc) && ready_i;
            kl = kill_i;
            @(posedge clk); #1;
            k++;
            ready_i = 1'b0; kill_i = 1'b0;
            if (hs || kl) pend = 0;
        end
        if (pend) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: no completion for funct3 %0d", f3);
            pend = 0;
        end
    endtask

    initial begin
        logic [2:0] f3;
        logic [63:0] a, b;
        int r;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_o", {63'b0, valid_o}, 64'd0);
        chk("rst_result_o", result_o, 64'd0);
        chk("rst_rd_o", {59'b0, rd_o}, 64'd0);
        chk("rst_illegal_o", {63'b0, illegal_o}, 64'd0);
        chk("rst_ready_o", {63'b0, ready_o}, 64'd1);
        rstn_i = 1'b1;
        chk_en = 1;

        issue(F3_GET, 64'd0, 64'd0, 5'd1, 0, -1, 1, 64'd0, 1);
        issue(F3_SET, 64'h3, 64'd0, 5'd2, 0, -1, 1, 64'd3, 1);
        issue(F3_GET, 64'd0, 64'd0, 5'd3, 0, -1, 1, 64'd3, 1);
        issue(F3_IP, 64'h0102030405060708, 64'h0101010101010101, 5'd4, 0, -1, 1, 64'd36, 9);
        issue(F3_SET, 64'h0, 64'd0, 5'd5, 0, -1, 1, 64'd0, 1);
`ifdef QNN_BSEG_SIGNED_EN
        issue(F3_IP, 64'hFFFFFFFFFFFFFFFF, 64'h00000000FFFFFFFF, 5'd6, 0, -1, 1, 64'd0, 65);
`else
        issue(F3_IP, 64'hFFFFFFFFFFFFFFFF, 64'h00000000FFFFFFFF, 5'd6, 0, -1, 1, 64'd32, 65);
`endif
        // Backpressure: result held for 5 cycles with ready_i low.
        issue(F3_GET, 64'd0, 64'd0, 5'd7, 5, -1, 1, 64'd0, 1);
        // Kill in BUSY cycle 3, then seg_log still reads back.
        issue(F3_SET, 64'h2, 64'd0, 5'd8, 0, -1, 1, 64'd2, 1);
        issue(F3_IP, {$urandom, $urandom}, {$urandom, $urandom}, 5'd9, 0, 3, 0, 64'd0, 17);
        issue(F3_GET, 64'd0, 64'd0, 5'd10, 0, -1, 1, 64'd2, 1);
        // kill_i with valid_i in the same cycle: SET must not be accepted.
        @(posedge clk); #1;
        valid_i = 1'b1; kill_i = 1'b1; funct3_i = F3_SET; rs1_data_i = 64'h1;
        @(posedge clk); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        issue(F3_GET, 64'd0, 64'd0, 5'd11, 0, -1, 1, 64'd2, 1);
        issue(F3_GP2, {$urandom, $urandom}, 64'd5, 5'd12, 1, -1, 1, 64'd0, 1);
        issue(F3_GET, 64'd0, 64'd0, 5'd13, 0, -1, 1, 64'd2, 1);

        // Reset in the middle of an IP clears state and seg_log.
        chk_en = 0;
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = F3_IP; rs1_data_i = '1; rs2_data_i = '1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1; rstn_i = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid_o", {63'b0, valid_o}, 64'd0);
        chk("midrst_result_o", result_o, 64'd0);
        chk("midrst_ready_o", {63'b0, ready_o}, 64'd1);
        rstn_i = 1'b1;
        m_seg = 2'd0;
        chk_en = 1;
        issue(F3_GET, 64'd0, 64'd0, 5'd14, 0, -1, 1, 64'd0, 1);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      f3 = F3_SET;
            else if (r < 35) f3 = F3_GET;
            else if (r < 80) f3 = F3_IP;
            else             f3 = 3'($urandom_range(3, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) a = '1;
            if ($urandom_range(0, 4) == 0) b = '1;
            issue(f3, a, b, 5'($urandom), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 20)) : -1, 0, 64'd0, 0);
        end

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
